// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
// Bundles the signals between the fetch stage, its control inputs, the
// instruction ROM and the IF/ID latch consumer.
//   stall, branch_en, branch_target : pipeline control into fetch
//   rom_ce, rom_addr                : ROM chip enable and byte address
//   rom_data                        : ROM read data (valid only while rom_ce=1)
//   if_id_pc, if_id_inst,
//   if_id_valid                     : registered IF/ID latch contents
//   addr_err                        : sticky misaligned-branch fault
// modport master : the fetch unit itself
// modport slave  : the environment (ROM, decode, hazard/branch logic)
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              stall;
    logic              branch_en;
    logic [ADDR_W-1:0] branch_target;
    logic              rom_ce;
    logic [ADDR_W-1:0] rom_addr;
    logic [INST_W-1:0] rom_data;
    logic [ADDR_W-1:0] if_id_pc;
    logic [INST_W-1:0] if_id_inst;
    logic              if_id_valid;
    logic              addr_err;

    modport master (
        input  stall, branch_en, branch_target, rom_data,
        output rom_ce, rom_addr, if_id_pc, if_id_inst, if_id_valid, addr_err
    );

    modport slave (
        output stall, branch_en, branch_target, rom_data,
        input  rom_ce, rom_addr, if_id_pc, if_id_inst, if_id_valid, addr_err
    );
endinterface

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
// Instruction-fetch stage: owns the PC, drives the instruction ROM and loads
// the IF/ID latch with one instruction per cycle.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : inst_fetch_unit_if.master (control in, ROM bus, IF/ID out, fault)
// Behaviour summary:
//   IDLE  -> FETCH one cycle after reset (enables the ROM).
//   FETCH -> captures ROM data into IF/ID and advances PC, holds on stall,
//            redirects on an aligned branch (inserting a bubble), or faults
//            into HALT on a misaligned branch.
//   HALT  -> everything frozen, ROM disabled, only rst leaves.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
    parameter int                  ADDR_W   = 32,
    parameter int                  INST_W   = 32,
    parameter logic [ADDR_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter int                  PC_STEP  = 4
) (
    input  logic             clk,
    input  logic             rst,
    inst_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_HALT  = 2'b10
    } state_t;

    state_t            state_q,       state_d;
    logic [ADDR_W-1:0] pc_q,          pc_d;
    logic              rom_ce_q,      rom_ce_d;
    logic [ADDR_W-1:0] if_id_pc_q,    if_id_pc_d;
    logic [INST_W-1:0] if_id_inst_q,  if_id_inst_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic              addr_err_q,    addr_err_d;

    logic              target_misaligned_s;

    // Word alignment of a redirect target: the two byte-offset bits must be zero.
    assign target_misaligned_s = (bus.branch_target[1:0] != 2'b00);

    // Next-state and next-output logic; every register holds unless changed.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        rom_ce_d      = rom_ce_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_inst_d  = if_id_inst_q;
        if_id_valid_d = if_id_valid_q;
        addr_err_d    = addr_err_q;

        case (state_q)
            ST_IDLE: begin
                // Enable the ROM; the first capture happens on the following edge.
                state_d  = ST_FETCH;
                rom_ce_d = 1'b1;
            end
            ST_FETCH: begin
                if (bus.branch_en) begin
                    // Redirect wins over stall; the in-flight word is discarded.
                    if_id_pc_d    = '0;
                    if_id_inst_d  = '0;
                    if_id_valid_d = 1'b0;
                    if (target_misaligned_s) begin
                        // Fault: PC keeps the old value, ROM is released.
                        addr_err_d = 1'b1;
                        state_d    = ST_HALT;
                        rom_ce_d   = 1'b0;
                    end else begin
                        pc_d = bus.branch_target;
                    end
                end else if (!bus.stall) begin
                    // ROM data is only meaningful while the chip is enabled.
                    if (rom_ce_q) begin
                        if_id_pc_d    = pc_q;
                        if_id_inst_d  = bus.rom_data;
                        if_id_valid_d = 1'b1;
                        pc_d          = pc_q + ADDR_W'(PC_STEP);
                    end else begin
                        pc_d = pc_q;
                    end
                end else begin
                    // Stalled: PC and IF/ID hold, ROM stays enabled.
                    rom_ce_d = 1'b1;
                end
            end
            ST_HALT: begin
                rom_ce_d = 1'b0;
            end
            default: begin
                state_d  = ST_IDLE;
                rom_ce_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            rom_ce_q      <= 1'b0;
            if_id_pc_q    <= '0;
            if_id_inst_q  <= '0;
            if_id_valid_q <= 1'b0;
            addr_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            rom_ce_q      <= rom_ce_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_inst_q  <= if_id_inst_d;
            if_id_valid_q <= if_id_valid_d;
            addr_err_q    <= addr_err_d;
        end
    end

    assign bus.rom_ce      = rom_ce_q;
    assign bus.rom_addr    = pc_q;
    assign bus.if_id_pc    = if_id_pc_q;
    assign bus.if_id_inst  = if_id_inst_q;
    assign bus.if_id_valid = if_id_valid_q;
    assign bus.addr_err    = addr_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
// Scoreboarded bench. The driver applies inputs on the falling edge, steps a
// behavioural model of the fetch stage for the coming rising edge and pushes
// the expected visible outputs into a queue. A monitor pops one entry after
// every rising edge and compares it against the DUT.
// Two DUTs: dut0 with RESET_PC=0 gets directed + random stimulus; dut1 with
// RESET_PC=FFFF_FFFC free-runs (no stall/branch) to exercise PC wrap.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

    localparam logic [31:0] POISON = 32'hBAD0_BAD0;

    typedef struct packed {
        logic [1:0]  mode;   // 0: not yet fetching, 1: fetching, 2: halted
        logic [31:0] pc;
        logic        ce;
        logic [31:0] ipc;
        logic [31:0] inst;
        logic        valid;
        logic        err;
    } model_t;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    model_t q0[$];
    model_t q1[$];
    model_t m0, m1;

    inst_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) if0 ();
    inst_fetch_unit_if #(.ADDR_W(32), .INST_W(32)) if1 ();

    inst_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'h0000_0000), .PC_STEP(4)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    inst_fetch_unit #(.ADDR_W(32), .INST_W(32), .RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    always #5 clk = ~clk;

    // ROM contents: test-plan words at 0x00..0x0F, an address-derived pattern elsewhere.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h1122_3344;
            32'h0000_0004: return 32'h5566_7788;
            32'h0000_0008: return 32'h99AA_BBCC;
            32'h0000_000C: return 32'hDDEE_FF00;
            default:       return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
        endcase
    endfunction

    // The ROM bus floats while disabled; a poison word stands in for Z.
    assign if0.rom_data = if0.rom_ce ? rom_word(if0.rom_addr) : POISON;
    assign if1.rom_data = if1.rom_ce ? rom_word(if1.rom_addr) : POISON;

    // Reference model: effect of one rising edge on the visible fetch-stage state.
    function automatic model_t step(input model_t m, input logic r, input logic s,
                                    input logic b, input logic [31:0] t,
                                    input logic [31:0] rpc);
        model_t n;
        n = m;
        if (r) begin
            n = '{mode: 2'd0, pc: rpc, ce: 1'b0, ipc: 32'd0, inst: 32'd0, valid: 1'b0, err: 1'b0};
        end else if (m.mode == 2'd0) begin
            n.mode = 2'd1;
            n.ce   = 1'b1;
        end else if (m.mode == 2'd1) begin
            if (b) begin
                n.ipc   = 32'd0;
                n.inst  = 32'd0;
                n.valid = 1'b0;
                if (t[1:0] != 2'b00) begin
                    n.err  = 1'b1;
                    n.mode = 2'd2;
                    n.ce   = 1'b0;
                end else begin
                    n.pc = t;
                end
            end else if (!s) begin
                n.ipc   = m.pc;
                n.inst  = rom_word(m.pc);
                n.valid = 1'b1;
                n.pc    = m.pc + 32'd4;
            end
        end
        return n;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected snapshot per rising edge per DUT.
    always begin
        model_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            cmp("dut0.rom_ce",      {31'd0, if0.rom_ce},      {31'd0, e.ce});
            cmp("dut0.rom_addr",    if0.rom_addr,             e.pc);
            cmp("dut0.if_id_pc",    if0.if_id_pc,             e.ipc);
            cmp("dut0.if_id_inst",  if0.if_id_inst,           e.inst);
            cmp("dut0.if_id_valid", {31'd0, if0.if_id_valid}, {31'd0, e.valid});
            cmp("dut0.addr_err",    {31'd0, if0.addr_err},    {31'd0, e.err});
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            cmp("dut1.rom_ce",      {31'd0, if1.rom_ce},      {31'd0, e.ce});
            cmp("dut1.rom_addr",    if1.rom_addr,             e.pc);
            cmp("dut1.if_id_pc",    if1.if_id_pc,             e.ipc);
            cmp("dut1.if_id_inst",  if1.if_id_inst,           e.inst);
            cmp("dut1.if_id_valid", {31'd0, if1.if_id_valid}, {31'd0, e.valid});
            cmp("dut1.addr_err",    {31'd0, if1.addr_err},    {31'd0, e.err});
        end
    end

    // Drive one cycle of stimulus and queue the expected result of the next edge.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t);
        @(negedge clk);
        rst               = r;
        if0.stall         = s;
        if0.branch_en     = b;
        if0.branch_target = t;
        m0 = step(m0, r, s, b, t, 32'h0000_0000);
        m1 = step(m1, r, 1'b0, 1'b0, 32'd0, 32'hFFFF_FFFC);
        q0.push_back(m0);
        q1.push_back(m1);
    endtask

    initial begin
        logic        rs, st, br;
        logic [31:0] tg;
        rst               = 1'b1;
        if0.stall         = 1'b0;
        if0.branch_en     = 1'b0;
        if0.branch_target = 32'd0;
        if1.stall         = 1'b0;
        if1.branch_en     = 1'b0;
        if1.branch_target = 32'd0;
        m0 = '0;
        m1 = '0;

        // Reset, release, sequential fetch from 0.
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        // Stall three cycles with pc=8, then resume.
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);

        // Branch + stall together at pc=8 to 0x0C.
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b1, 1'b1, 32'h0000_000C);
        for (int i = 0; i < 2; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);

        // Misaligned target, frozen while halted (branch attempts ignored), then reset.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0006);
        for (int i = 0; i < 10; i++) cyc(1'b0, i[0], i[1], 32'h0000_0040);
        cyc(1'b1, 1'b0, 1'b0, 32'd0);
        // Branch during IDLE is ignored.
        cyc(1'b0, 1'b0, 1'b1, 32'h0000_0020);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset together with a branch: reset wins.
        cyc(1'b1, 1'b0, 1'b1, 32'h0000_0030);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 32'd0);

        // Branch to the top word to exercise wrap on dut0 as well.
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 32'd0);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            rs = ($urandom_range(0, 99) < 2);
            st = ($urandom_range(0, 99) < 25);
            br = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 9) == 0)
                tg = 32'hFFFF_FFFC;
            else
                tg = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
            if ($urandom_range(0, 9) < 2)
                tg[1:0] = 2'($urandom_range(1, 3));
            cyc(rs, st, br, tg);
        end

        @(posedge clk);
        #2;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q0.size() + q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
